// File: rtl/debug_halt_ctrl_pkg.sv
// Shared definitions for the PIC16C55 debug run-control block.
// Holds the run-control state encoding and the register-file width defaults.
package debug_halt_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        DBG_RUN     = 3'd0,
        DBG_HALTING = 3'd1,
        DBG_HALTED  = 3'd2,
        DBG_STEP    = 3'd3,
        DBG_ACCESS  = 3'd4,
        DBG_ACK     = 3'd5
    } dbg_state_e;

    // States in which the core is frozen and the host may own the register file.
    function automatic logic is_halted_state(input dbg_state_e s);
        return (s == DBG_HALTED) || (s == DBG_ACCESS) || (s == DBG_ACK);
    endfunction

endpackage

// File: rtl/debug_halt_ctrl.sv
// Debug run-control and register-file port arbiter for the PIC16C55 core.
// Halts, single-steps and resumes on instruction boundaries and grants host RF access while halted.
module debug_halt_ctrl
    import debug_halt_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH    = 16,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_q4,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  core_en,
    input  logic                  halt_req,
    input  logic                  step,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  icount
);

    localparam dbg_state_e           RESET_STATE = RESET_HALTED ? DBG_HALTED : DBG_RUN;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    dbg_state_e            state_q, state_d;
    logic                  halted_q;
    logic                  dbg_ack_q;
    logic [DATA_WIDTH-1:0] dbg_rdata_q;
    logic [CNT_WIDTH-1:0]  icount_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            halted_q    <= RESET_HALTED;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
            icount_q    <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= is_halted_state(state_d);
            dbg_ack_q <= (state_d == DBG_ACK);
            if ((state_q == DBG_ACCESS) && !dbg_we) begin
                dbg_rdata_q <= rf_rdata;
            end
            if (core_q4 && core_en) begin
                icount_q <= icount_q + CNT_ONE;
            end
        end
    end

    // Every exit from a core-enabled state waits for core_q4, so core_en only
    // drops on an instruction boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DBG_RUN: begin
                if (halt_req) begin
                    state_d = core_q4 ? DBG_HALTED : DBG_HALTING;
                end
            end
            DBG_HALTING: begin
                if (core_q4) state_d = DBG_HALTED;
            end
            DBG_HALTED: begin
                if (dbg_req)        state_d = DBG_ACCESS;
                else if (step)      state_d = DBG_STEP;
                else if (!halt_req) state_d = DBG_RUN;
            end
            DBG_STEP: begin
                if (core_q4) state_d = DBG_HALTED;
            end
            DBG_ACCESS: state_d = DBG_ACK;
            DBG_ACK:    state_d = DBG_HALTED;
            default:    state_d = RESET_STATE;
        endcase
    end

    always_comb begin
        core_en  = (state_q == DBG_RUN) || (state_q == DBG_HALTING) || (state_q == DBG_STEP);
        rf_we    = 1'b0;
        rf_addr  = dbg_addr;
        rf_wdata = dbg_wdata;
        if (core_en) begin
            rf_we    = core_we;
            rf_addr  = core_addr;
            rf_wdata = core_wdata;
        end else if (state_q == DBG_ACCESS) begin
            rf_we = dbg_we;
        end
        // Keep the register file untouched while reset is held.
        if (rst) begin
            rf_we = 1'b0;
        end
    end

    assign halted    = halted_q;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;
    assign icount    = icount_q;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Scoreboarded bench for debug_halt_ctrl: a 4-phase core model, a register-file model,
// and a second instance (reset-halted, 4-bit counter) for reset-halted and wrap behaviour.
module tb_debug_halt_ctrl;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_q4, core_we, core_en;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, rf_rdata, rf_wdata, dbg_wdata, dbg_rdata;
    logic          rf_we, halt_req, step, dbg_req, dbg_we, dbg_ack, halted;
    logic [AW-1:0] rf_addr, dbg_addr;
    logic [CW-1:0] icount;

    logic          q4_2, core_en2, rf_we2, dbg_ack2, halted2, halt_req2;
    logic [AW-1:0] rf_addr2;
    logic [DW-1:0] rf_wdata2, dbg_rdata2;
    logic [3:0]    icount2;
    logic [1:0]    phase, phase2;

    always #5 clk = ~clk;

    debug_halt_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .RESET_HALTED(1'b0)) dut (
        .clk(clk), .rst(rst), .core_q4(core_q4), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_addr(rf_addr),
        .rf_wdata(rf_wdata), .core_en(core_en), .halt_req(halt_req), .step(step),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .halted(halted), .icount(icount)
    );

    debug_halt_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(4), .RESET_HALTED(1'b1)) u_rh (
        .clk(clk), .rst(rst), .core_q4(q4_2), .core_we(1'b0), .core_addr(5'h00),
        .core_wdata(8'h00), .rf_rdata(8'h00), .rf_we(rf_we2), .rf_addr(rf_addr2),
        .rf_wdata(rf_wdata2), .core_en(core_en2), .halt_req(halt_req2), .step(1'b0),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(5'h00), .dbg_wdata(8'h00),
        .dbg_ack(dbg_ack2), .dbg_rdata(dbg_rdata2), .halted(halted2), .icount(icount2)
    );

    // 4-phase core: the Q counter only advances while the core is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= 2'd0;
        else if (core_en) phase <= phase + 2'd1;
    end
    assign core_q4    = (phase == 2'd3);
    assign core_we    = core_en && core_q4;
    assign core_addr  = 5'h1F;
    assign core_wdata = 8'hA5;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase2 <= 2'd0;
        else if (core_en2) phase2 <= phase2 + 2'd1;
    end
    assign q4_2 = (phase2 == 2'd3);

    logic [DW-1:0] regs [32];
    always_ff @(posedge clk) begin
        if (rf_we) regs[rf_addr] <= rf_wdata;
    end
    assign rf_rdata = regs[rf_addr];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ack_seen    = 0;
    int host_we_cnt = 0;
    int en_cnt      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [7:0]  rdata;
        string       name;
    } exp_t;
    exp_t sb[$];

    task automatic push_exp(input string name, input int at_cyc, input logic [7:0] rd);
        exp_t e;
        e.cyc   = at_cyc;
        e.rdata = rd;
        e.name  = name;
        sb.push_back(e);
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_we && !core_en) host_we_cnt++;
            if (core_en) en_cnt++;
            if (dbg_ack) begin
                ack_seen++;
                if (sb.size() == 0) begin
                    chk("ack_unexpected", {31'd0, dbg_ack}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_ack_cycle"}, cyc, e.cyc);
                    chk({e.name, "_rdata"}, {24'd0, dbg_rdata}, {24'd0, e.rdata});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!dbg_ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!dbg_ack) chk({name, "_ack_timeout"}, {31'd0, dbg_ack}, 32'd1);
        dbg_req = 1'b0;
    endtask

    task automatic host_access(input string name, input logic we, input logic [4:0] a,
                               input logic [7:0] wd, input logic [7:0] exp_rd);
        tick();
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = wd;
        push_exp(name, cyc + 2, exp_rd);
        wait_ack(name);
    endtask

    task automatic wait_halted(input string name);
        int n;
        n = 0;
        while (!halted && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_q4();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_q4 && n < 10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, lat, we0, a0, e0, bad;
        logic [4:0] hbits, ebits;

        rst = 1'b1; halt_req = 1'b0; step = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
        dbg_addr = '0; dbg_wdata = '0; halt_req2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_core_en",  {31'd0, core_en}, 32'd1);
        chk("rst_halted",   {31'd0, halted}, 32'd0);
        chk("rst_dbg_ack",  {31'd0, dbg_ack}, 32'd0);
        chk("rst_dbg_rdata", {24'd0, dbg_rdata}, 32'd0);
        chk("rst_icount",   {16'd0, icount}, 32'd0);
        chk("rst_rf_we",    {31'd0, rf_we}, 32'd0);
        chk("rst2_halted",  {31'd0, halted2}, 32'd1);
        chk("rst2_core_en", {31'd0, core_en2}, 32'd0);
        tick();
        rst = 1'b0;

        // Halt requested one clock after the 6th Q4: HALTED after the 7th instruction.
        n = 0;
        while (n < 6) begin
            @(negedge clk);
            if (core_q4) n++;
        end
        tick();
        halt_req = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!halted && lat < 10);
        chk("halt_latency_clocks", lat, 5);
        chk("halt_core_en", {31'd0, core_en}, 32'd0);
        chk("halt_icount", {16'd0, icount}, 32'd7);

        we0 = host_we_cnt;
        host_access("wr_0a", 1'b1, 5'h0A, 8'h5C, 8'h00);
        chk("wr_rf_we_clocks", host_we_cnt - we0, 1);
        chk("wr_rf_content", {24'd0, regs[5'h0A]}, 32'h5C);
        host_access("rd_0a", 1'b0, 5'h0A, 8'h00, 8'h5C);
        host_access("wr_03", 1'b1, 5'h03, 8'h77, 8'h5C);
        host_access("rd_03", 1'b0, 5'h03, 8'h00, 8'h77);

        tick(); step = 1'b1;
        tick(); step = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (core_en) n++;
        end
        chk("step_core_en_clocks", n, 4);
        chk("step_icount", {16'd0, icount}, 32'd8);
        chk("step_halted", {31'd0, halted}, 32'd1);

        // Step and access together: access wins, step is lost.
        e0 = en_cnt;
        tick();
        step = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'h0A;
        push_exp("rd_with_step", cyc + 2, 8'h5C);
        tick();
        step = 1'b0;
        wait_ack("rd_with_step");
        repeat (6) @(negedge clk);
        chk("step_dropped_core_en", en_cnt - e0, 0);
        chk("step_dropped_icount", {16'd0, icount}, 32'd8);

        tick(); halt_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("resume_core_en", {31'd0, core_en}, 32'd1);
        chk("resume_halted", {31'd0, halted}, 32'd0);

        // Host request while running must wait; the core keeps the RF port.
        a0 = ack_seen;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'h0A;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (rf_addr !== core_addr || rf_we !== core_we || rf_wdata !== core_wdata) bad++;
        end
        chk("run_core_owns_rf", bad, 0);
        chk("run_no_ack", ack_seen - a0, 0);
        tick(); halt_req = 1'b1;
        wait_halted("run_halt_reached");
        push_exp("rd_after_halt", cyc + 2, 8'h5C);
        wait_ack("rd_after_halt");

        // Dropping halt_req while HALTING: HALTED still reached, then RUN next clock.
        tick(); halt_req = 1'b0;
        repeat (2) @(negedge clk);
        wait_q4();
        tick(); halt_req = 1'b1;
        tick(); halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            hbits[i] = halted;
            ebits[i] = core_en;
        end
        chk("halting_drop_halted_seq", {27'd0, hbits}, 32'b01000);
        chk("halting_drop_core_en_seq", {27'd0, ebits}, 32'b10111);

        // Reset-halted instance: release it and watch its 4-bit counter wrap.
        tick(); halt_req2 = 1'b0;
        n = 0;
        while (icount2 != 4'hF && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_reach_f", {28'd0, icount2}, 32'hF);
        n = 0;
        while (icount2 == 4'hF && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_to_zero", {28'd0, icount2}, 32'h0);
        chk("wrap_clocks_at_f", n, 4);

        // Reset while an access is in flight: no ack, no write, clean restart.
        tick(); halt_req = 1'b1;
        wait_halted("rst_access_halt_reached");
        a0 = ack_seen;
        tick();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'h0A; dbg_wdata = 8'hEE;
        tick();
        rst = 1'b1;
        tick();
        dbg_req = 1'b0; halt_req = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_core_en", {31'd0, core_en}, 32'd1);
        chk("post_rst_halted", {31'd0, halted}, 32'd0);
        chk("post_rst_icount", {16'd0, icount}, 32'd0);
        chk("post_rst_dbg_rdata", {24'd0, dbg_rdata}, 32'd0);
        chk("post_rst2_halted", {31'd0, halted2}, 32'd1);
        chk("post_rst2_icount", {28'd0, icount2}, 32'd0);
        repeat (4) @(negedge clk);
        chk("rst_access_no_ack", ack_seen - a0, 0);
        chk("rst_access_no_write", {24'd0, regs[5'h0A]}, 32'h5C);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debug_halt_ctrl.md
# debug_halt_ctrl

Debug run-control and register-file arbiter for the PIC16C55 core. It gates core execution on instruction-cycle boundaries, so the core can halt, single-step or resume. It also multiplexes the register-file address/write port between the core writeback path and a debug host. Host access is allowed only while the core is halted. It sits between the core datapath (PC/IR/ControlUnit/RegFileWriteControl) and the RegisterFile instance.

## Interface
- DATA_WIDTH, 8, register-file data width
- ADDR_WIDTH, 5, register-file address width (matches IR[4:0])
- CNT_WIDTH, 16, retired-instruction counter width
- RESET_HALTED, 0, 1 = leave reset in HALTED instead of RUN

- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- core_q4  input  1  high during the last clock (Q4) of every core instruction cycle
- core_we  input  1  core register-file write strobe
- core_addr  input  ADDR_WIDTH  core register-file address
- core_wdata  input  DATA_WIDTH  core write data
- rf_rdata  input  DATA_WIDTH  register-file read data (combinational from rf_addr)
- rf_we  output  1  muxed write strobe to register file
- rf_addr  output  ADDR_WIDTH  muxed address
- rf_wdata  output  DATA_WIDTH  muxed write data
- core_en  output  1  clock enable for PC, IR, ControlUnit, W, stack
- halt_req  input  1  level; request halt / hold halted
- step  input  1  one-clock pulse; execute one instruction while halted
- dbg_req  input  1  host access request, held until dbg_ack
- dbg_we  input  1  1 = write, 0 = read
- dbg_addr  input  ADDR_WIDTH  host address
- dbg_wdata  input  DATA_WIDTH  host write data
- dbg_ack  output  1  one-clock completion pulse
- dbg_rdata  output  DATA_WIDTH  read data, valid with dbg_ack and held until next read
- halted  output  1  high in HALTED, ACCESS and ACK
- icount  output  CNT_WIDTH  instructions retired (core_q4 && core_en), wraps modulo 2^CNT_WIDTH

## Operation
- States: RUN, HALTING, HALTED, STEP, ACCESS, ACK.
- RUN: core_en=1; rf_* driven from core_*.
  - halt_req && core_q4 → HALTED.
  - halt_req && !core_q4 → HALTING.
- HALTING: core_en=1, core drives rf_*. On core_q4 → HALTED. This transition is committed: dropping halt_req here does not cancel it.
- HALTED: core_en=0; rf_we=0; rf_addr=dbg_addr. Priority, highest first:
  - dbg_req → ACCESS
  - step → STEP
  - !halt_req → RUN
- ACCESS (1 clock): rf_addr=dbg_addr, rf_wdata=dbg_wdata, rf_we=dbg_we. For reads, dbg_rdata captures rf_rdata at the clock edge. Next state is ACK.
- ACK (1 clock): dbg_ack=1, rf_we=0. Next state is HALTED. The host must drop dbg_req in this cycle or present a new request. A request still high in HALTED is treated as a new access.
- STEP: core_en=1, core drives rf_*. On core_q4 → HALTED, regardless of halt_req. A step pulse outside HALTED is ignored.
- dbg_req outside HALTED is not acknowledged and waits, with no timeout.
- core_en never changes in the middle of an instruction cycle. Its transitions to 0 occur only on the clock after a core_q4.
- Reset: state = RESET_HALTED ? HALTED : RUN. Outputs under reset:
  - core_en = !RESET_HALTED
  - dbg_ack=0, dbg_rdata=0, icount=0, rf_we=0
  - halted = RESET_HALTED
- Reset mid-access drops the access with no ack.

## Timing
- Halt latency: core_en falls on the clock after the first core_q4 at or after halt_req is sampled high. The worst case is 4 clocks.
- Host access: dbg_req sampled in HALTED; ACCESS next clock; dbg_ack on the clock after that. dbg_ack rises 2 clocks after the request edge. Back-to-back accesses run every 3 clocks.
- Step: core_en high for exactly one instruction cycle (4 clocks with a 4-phase core). icount increments by 1.
- icount updates on the edge ending a core_q4 clock where core_en=1.
- All outputs are registered except rf_* and core_en, which decode the current state combinationally.

## Structure
- Shared package/define file (next to define.v) holds the state encoding constants DBG_RUN … DBG_ACK (3 bits), and DATA_WIDTH/ADDR_WIDTH defaults.
- Single module; no sub-module. The icount counter is inline.

## Test plan
- Halt from RUN: halt_req rises 1 clock after core_q4 → HALTING for 3 clocks; core_en=0 the clock after the next core_q4; halted=1.
- Host write then read while halted:
  - write dbg_addr=0x0A, dbg_wdata=0x5C → rf_we=1 for exactly 1 clock, dbg_ack 2 clocks after the request.
  - read 0x0A → dbg_rdata=0x5C with dbg_ack.
- Host request while running: dbg_req held in RUN, no ack; halt_req asserted → access completes 2 clocks after HALTED is entered; core writes are never overridden.
- Single step: in HALTED with icount=0x0007, step pulse → core_en=1 for 4 clocks, icount=0x0008, back in HALTED. A step arriving simultaneously with dbg_req → access first, step dropped.
- Resume and boundaries:
  - halt_req drops in HALTING → HALTED is still reached, then RUN the next clock.
  - icount=0xFFFF wraps to 0x0000.
- Reset mid-operation: rst asserted during ACCESS → no dbg_ack; after release state=RUN (RESET_HALTED=0) or HALTED (RESET_HALTED=1); icount=0, dbg_rdata=0.
